// File: rtl/mips20_pkg.sv
// Shared encodings for the 20-bit multi-cycle MIPS control path: opcodes, ALU
// operation codes, datapath mux selects and the main FSM state type.
package mips20_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_ADDI = 4'b0110;
  localparam logic [3:0] OP_ANDI = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_JMEM = 4'b1100;

  localparam logic [3:0] ALU_IDLE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_LWA  = 4'b1000;
  localparam logic [3:0] ALU_SWA  = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1011;
  localparam logic [3:0] ALU_JMEM = 4'b1100;

  localparam logic [1:0] SRCB_RT  = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_MDR    = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_MEM,
    S_BRANCH,
    S_JM_ADDR,
    S_JM_RD,
    S_JM_PC,
    S_HALT
  } state_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SLT);
  endfunction

  // States that hold mem_req and are therefore subject to the wait timeout.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR) || (s == S_JM_RD);
  endfunction

endpackage

// File: rtl/mc_control_alu_op_decode.sv
// Combinational aluop selection from the FSM state and the IR opcode.
module alu_op_decode
  import mips20_pkg::*;
(
  input  state_t     state_i,
  input  logic [3:0] opcode_i,
  output logic [3:0] aluop_o
);

  // Execute-class states forward the opcode, since the ALU codes match it.
  always_comb begin
    aluop_o = ALU_IDLE;
    case (state_i)
      S_FETCH, S_DECODE: aluop_o = ALU_ADD;
      S_EXEC_R, S_EXEC_I: aluop_o = opcode_i;
      S_MEM_ADDR: aluop_o = (opcode_i == OP_LW) ? ALU_LWA : ALU_SWA;
      S_BRANCH: aluop_o = ALU_BEQ;
      S_JM_ADDR: aluop_o = ALU_JMEM;
      default: aluop_o = ALU_IDLE;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle main control FSM for the 20-bit MIPS core.
// Optional build macro ILLEGAL_TRAP_EN: illegal opcodes halt and raise 'illegal'.
module mc_control
  import mips20_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zeros,
  input  logic       mem_ready,
  output logic [3:0] aluop,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       bus_err
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  localparam logic [15:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? 16'(MEM_TIMEOUT - 1) : 16'd0;

  state_t      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        bus_err_q, bus_err_d;
  logic        in_mem;
  logic        stalled;
  logic [3:0]  aluop_dec;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  alu_op_decode u_alu_op_decode (
    .state_i  (state_q),
    .opcode_i (opcode),
    .aluop_o  (aluop_dec)
  );

  assign in_mem  = is_mem_state(state_q);
  assign stalled = in_mem && !mem_ready && (MEM_TIMEOUT != 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    bus_err_d = bus_err_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_rtype(opcode)) begin
          state_d = S_EXEC_R;
        end else begin
          case (opcode)
            OP_ADDI, OP_ANDI: state_d = S_EXEC_I;
            OP_LW, OP_SW:     state_d = S_MEM_ADDR;
            OP_BEQ:           state_d = S_BRANCH;
            OP_JMEM:          state_d = S_JM_ADDR;
            OP_NOP:           state_d = S_FETCH;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              state_d   = S_HALT;
              illegal_d = 1'b1;
`else
              state_d   = S_FETCH;
`endif
            end
          endcase
        end
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_I:     state_d = S_FETCH;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_WB_MEM:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JM_ADDR:  state_d = S_JM_RD;
      S_JM_RD:    if (mem_ready) state_d = S_JM_PC;
      S_JM_PC:    state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase

    // The wait that would complete the count is the one that trips the timeout.
    if (stalled && (wait_q == WAIT_LAST)) begin
      state_d   = S_HALT;
      bus_err_d = 1'b1;
    end

    if (state_d != state_q) begin
      wait_d = '0;
    end else if (stalled) begin
      wait_d = wait_q + 16'd1;
    end
  end

  // Reset forces every output low, even before the first edge establishes FETCH.
  always_comb begin
    aluop      = ALU_IDLE;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    bus_err    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal    = 1'b0;
`endif
    if (!rst) begin
      aluop   = aluop_dec;
      bus_err = bus_err_q;
`ifdef ILLEGAL_TRAP_EN
      illegal = illegal_q;
`endif
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_ONE;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = SRCB_IMM;
        S_EXEC_R: alu_src_a = 1'b1;
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_EXEC_I, S_MEM_ADDR, S_JM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_WB_I: reg_write = 1'b1;
        S_MEM_RD, S_JM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          pc_write  = zeros;
          pc_src    = PCSRC_ALUOUT;
        end
        S_JM_PC: begin
          pc_write = 1'b1;
          pc_src   = PCSRC_MDR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed scoreboard bench for mc_control built with MEM_TIMEOUT = 4;
// adapts to the ILLEGAL_TRAP_EN build.
module tb_mc_control;

  typedef struct {
    string       name;
    logic        rs;
    logic [3:0]  op;
    logic        mr;
    logic        z;
    logic [18:0] exp;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst, zeros, mem_ready;
  logic [3:0] opcode;
  logic [3:0] aluop;
  logic       alu_src_a, mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] alu_src_b, pc_src;
  logic       reg_write, reg_dst, mem_to_reg, bus_err;
  logic       illegal;

  entry_t sbq[$];
  int     vectors = 0;
  int     miscompares = 0;

  always #5 clk = ~clk;

  mc_control #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zeros      (zeros),
    .mem_ready  (mem_ready),
    .aluop      (aluop),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .bus_err    (bus_err)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal    (illegal)
`endif
  );

`ifndef ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  // Field order: aluop, src_a, src_b, req, we, iord, irw, pcw, pc_src, rw, rdst, m2r, berr, ill
  function automatic logic [18:0] pk(input logic [3:0] a, input logic sa, input logic [1:0] sb,
                                     input logic mq, input logic mw, input logic io,
                                     input logic irw, input logic pcw, input logic [1:0] ps,
                                     input logic rw, input logic rd, input logic m2r,
                                     input logic be, input logic il);
    return {a, sa, sb, mq, mw, io, irw, pcw, ps, rw, rd, m2r, be, il};
  endfunction

  function automatic logic [18:0] fetchV(input logic rdy);
    return pk(4'b0001, 0, 2'd1, 1, 0, 0, rdy, rdy, 2'd0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [18:0] decV();
    return pk(4'b0001, 0, 2'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [18:0] aluV(input logic [3:0] a, input logic [1:0] sb);
    return pk(a, 1, sb, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
  endfunction

  task automatic push(input string name, input logic rs, input logic [3:0] op,
                      input logic mr, input logic z, input logic [18:0] exp);
    entry_t e;
    e.name = name;
    e.rs   = rs;
    e.op   = op;
    e.mr   = mr;
    e.z    = z;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [18:0] exp);
    logic [18:0] obs;
    obs = {aluop, alu_src_a, alu_src_b, mem_req, mem_we, iord, ir_write, pc_write,
           pc_src, reg_write, reg_dst, mem_to_reg, bus_err, illegal};
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%05h expected=%05h", name, obs, exp);
    end
  endtask

  // Drive each queued step for one cycle and compare mid-low-phase.
  task automatic applyStimulus();
    entry_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk);
      rst       = e.rs;
      opcode    = e.op;
      mem_ready = e.mr;
      zeros     = e.z;
      #2;
      checkOutput(e.name, e.exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    zeros = 1'b0;
    opcode = 4'b0000;

    push("reset0", 1, 4'b0000, 1, 0, '0);
    push("reset1", 1, 4'b0000, 1, 0, '0);
    applyStimulus();

    push("add_fetch", 0, 4'b0001, 1, 0, fetchV(1));
    push("add_decode", 0, 4'b0001, 1, 0, decV());
    push("add_exec", 0, 4'b0001, 1, 0, aluV(4'b0001, 2'd0));
    push("add_wb", 0, 4'b0001, 1, 0, pk(4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 1, 0, 0, 0));
    applyStimulus();

    push("lw_fetch", 0, 4'b1000, 1, 0, fetchV(1));
    push("lw_decode", 0, 4'b1000, 0, 0, decV());
    push("lw_addr", 0, 4'b1000, 0, 0, aluV(4'b1000, 2'd2));
    for (int i = 0; i < 3; i++)
      push("lw_rd_wait", 0, 4'b1000, 0, 0, pk(4'b0000, 0, 2'd0, 1, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0));
    push("lw_rd_done", 0, 4'b1000, 1, 0, pk(4'b0000, 0, 2'd0, 1, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0));
    push("lw_wb", 0, 4'b1000, 1, 0, pk(4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 1, 0, 0));
    push("lw_next_fetch", 0, 4'b1011, 1, 0, fetchV(1));
    applyStimulus();

    push("beq1_decode", 0, 4'b1011, 1, 1, decV());
    push("beq1_branch", 0, 4'b1011, 1, 1, pk(4'b1011, 1, 2'd0, 0, 0, 0, 0, 1, 2'd1, 0, 0, 0, 0, 0));
    push("beq0_fetch", 0, 4'b1011, 1, 0, fetchV(1));
    push("beq0_decode", 0, 4'b1011, 1, 0, decV());
    push("beq0_branch", 0, 4'b1011, 1, 0, pk(4'b1011, 1, 2'd0, 0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 0));
    applyStimulus();

    push("jm_fetch", 0, 4'b1100, 1, 0, fetchV(1));
    push("jm_decode", 0, 4'b1100, 1, 0, decV());
    push("jm_addr", 0, 4'b1100, 1, 0, aluV(4'b1100, 2'd2));
    push("jm_rd_wait", 0, 4'b1100, 0, 0, pk(4'b0000, 0, 2'd0, 1, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0));
    push("jm_rd_done", 0, 4'b1100, 1, 0, pk(4'b0000, 0, 2'd0, 1, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0));
    push("jm_pc", 0, 4'b1100, 1, 0, pk(4'b0000, 0, 2'd0, 0, 0, 0, 0, 1, 2'd2, 0, 0, 0, 0, 0));
    applyStimulus();

    push("sw_fetch", 0, 4'b1001, 1, 0, fetchV(1));
    push("sw_decode", 0, 4'b1001, 1, 0, decV());
    push("sw_addr", 0, 4'b1001, 1, 0, aluV(4'b1001, 2'd2));
    push("sw_wr", 0, 4'b1001, 1, 0, pk(4'b0000, 0, 2'd0, 1, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0));
    applyStimulus();

    push("nop_fetch_wait0", 0, 4'b0000, 0, 0, fetchV(0));
    push("nop_fetch_wait1", 0, 4'b0000, 0, 0, fetchV(0));
    push("nop_fetch_done", 0, 4'b0000, 1, 0, fetchV(1));
    push("nop_decode", 0, 4'b0000, 1, 0, decV());
    applyStimulus();

    push("ill_fetch", 0, 4'b1111, 1, 0, fetchV(1));
    push("ill_decode", 0, 4'b1111, 1, 0, decV());
`ifdef ILLEGAL_TRAP_EN
    push("ill_halt0", 0, 4'b1111, 1, 0, pk(4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1));
    push("ill_halt1", 0, 4'b1111, 1, 0, pk(4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1));
`else
    push("ill_refetch", 0, 4'b1111, 0, 0, fetchV(0));
`endif
    push("ill_reset", 1, 4'b1111, 0, 0, '0);
    applyStimulus();

    push("mid_fetch_wait", 0, 4'b1001, 0, 0, fetchV(0));
    push("mid_reset", 1, 4'b1001, 0, 0, '0);
    push("to_fetch_done", 0, 4'b1001, 1, 0, fetchV(1));
    push("to_decode", 0, 4'b1001, 0, 0, decV());
    push("to_addr", 0, 4'b1001, 0, 0, aluV(4'b1001, 2'd2));
    for (int i = 0; i < 4; i++)
      push("to_wr_wait", 0, 4'b1001, 0, 0, pk(4'b0000, 0, 2'd0, 1, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0));
    push("to_halt0", 0, 4'b1001, 1, 0, pk(4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0));
    push("to_halt1", 0, 4'b1001, 1, 0, pk(4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0));
    push("to_reset", 1, 4'b1001, 1, 0, '0);
    push("to_after_reset", 0, 4'b1001, 0, 0, fetchV(0));
    applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
